// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for an in-order scalar pipeline.
// Tracks in-flight producers per stage and drives stall/freeze/flush/forward selects.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES       = 5,
   parameter int LOAD_READY_STAGE = 3,
   parameter int BRANCH_STAGE     = 3,
   parameter int REG_IDX_W        = 5,
   parameter int CNT_W            = 32,
   parameter int SEL_W            = $clog2(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_IDX_W-1:0]  id_rs1,
   input  logic [REG_IDX_W-1:0]  id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_IDX_W-1:0]  id_rd,
   input  logic                  id_reg_wr,
   input  logic                  id_rd_mem,
   input  logic                  mem_busy,
   input  logic                  redirect,
   output logic                  stall,
   output logic                  freeze,
   output logic [NUM_STAGES-1:0] flush_mask,
   output logic                  redirect_ack,
   output logic [SEL_W-1:0]      fwd_sel_a,
   output logic [SEL_W-1:0]      fwd_sel_b,
   output logic [CNT_W-1:0]      retired_cnt,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int LAST = NUM_STAGES - 1;
   localparam logic [NUM_STAGES-1:0] FLUSH_BITS =
      {NUM_STAGES{1'b1}} >> (NUM_STAGES - BRANCH_STAGE);

   logic                 r_vld [2:LAST];
   logic                 r_wr  [2:LAST];
   logic                 r_ld  [2:LAST];
   logic [REG_IDX_W-1:0] r_rd  [2:LAST];

   logic                 w_vld_n [2:LAST];
   logic                 w_wr_n  [2:LAST];
   logic                 w_ld_n  [2:LAST];
   logic [REG_IDX_W-1:0] w_rd_n  [2:LAST];

   logic [CNT_W-1:0] r_retired;
   logic [CNT_W-1:0] r_stalls;
   logic [CNT_W-1:0] r_flushes;

   logic [SEL_W-1:0] w_sel_a;
   logic [SEL_W-1:0] w_sel_b;
   logic             w_lu_a;
   logic             w_lu_b;
   logic             w_hazard;
   logic             w_ack;
   logic             w_stall;

   // Scanning oldest to youngest lets the youngest matching producer win.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      w_lu_a  = 1'b0;
      w_lu_b  = 1'b0;
      for (int s = LAST; s >= 2; s--) begin
         if (id_rs1_used && (id_rs1 != '0) && r_vld[s] && r_wr[s] && (r_rd[s] == id_rs1)) begin
            w_sel_a = SEL_W'(s);
            w_lu_a  = r_ld[s] && (s < LOAD_READY_STAGE);
         end
         if (id_rs2_used && (id_rs2 != '0) && r_vld[s] && r_wr[s] && (r_rd[s] == id_rs2)) begin
            w_sel_b = SEL_W'(s);
            w_lu_b  = r_ld[s] && (s < LOAD_READY_STAGE);
         end
      end
   end

   assign w_hazard = id_valid & (w_lu_a | w_lu_b);
   assign w_ack    = ~rst & ~mem_busy & redirect;
   assign w_stall  = ~rst & ~mem_busy & ~redirect & w_hazard;

   always_comb begin
      w_vld_n[2] = id_valid;
      w_wr_n[2]  = id_reg_wr & id_valid;
      w_ld_n[2]  = id_rd_mem & id_valid;
      w_rd_n[2]  = id_rd;
      for (int s = 3; s <= LAST; s++) begin
         w_vld_n[s] = r_vld[s-1];
         w_wr_n[s]  = r_wr[s-1];
         w_ld_n[s]  = r_ld[s-1];
         w_rd_n[s]  = r_rd[s-1];
      end
      // The branch itself survives into BRANCH_STAGE+1; everything younger is squashed.
      if (w_ack) begin
         for (int s = 2; s <= BRANCH_STAGE; s++) begin
            w_vld_n[s] = 1'b0;
            w_wr_n[s]  = 1'b0;
            w_ld_n[s]  = 1'b0;
         end
      end else if (w_stall) begin
         w_vld_n[2] = 1'b0;
         w_wr_n[2]  = 1'b0;
         w_ld_n[2]  = 1'b0;
      end
   end

   // Scoreboard stage boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 2; s <= LAST; s++) r_vld[s] <= 1'b0;
      end else if (!mem_busy) begin
         for (int s = 2; s <= LAST; s++) r_vld[s] <= w_vld_n[s];
      end
   end

   always_ff @(posedge clk) begin
      if (!mem_busy) begin
         for (int s = 2; s <= LAST; s++) begin
            r_wr[s] <= w_wr_n[s];
            r_ld[s] <= w_ld_n[s];
            r_rd[s] <= w_rd_n[s];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_retired <= '0;
         r_stalls  <= '0;
         r_flushes <= '0;
      end else if (!mem_busy) begin
         if (r_vld[LAST]) r_retired <= r_retired + CNT_W'(1);
         if (w_stall)     r_stalls  <= r_stalls + CNT_W'(1);
         if (w_ack)       r_flushes <= r_flushes + CNT_W'(1);
      end
   end

   assign stall        = w_stall;
   assign freeze       = mem_busy;
   assign redirect_ack = w_ack;
   assign flush_mask   = w_ack ? FLUSH_BITS : '0;
   assign fwd_sel_a    = w_sel_a;
   assign fwd_sel_b    = w_sel_b;
   assign retired_cnt  = r_retired;
   assign stall_cnt    = r_stalls;
   assign flush_cnt    = r_flushes;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: default (5/3/3) and scaled (7/4/4) instances
// driven in lockstep and compared against an instruction-list reference model.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_rd_mem, mem_busy, redirect;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic        s0_stall, s0_freeze, s0_ack;
   logic [4:0]  s0_flush;
   logic [2:0]  s0_sa, s0_sb;
   logic [31:0] s0_ret, s0_stc, s0_flc;

   logic        s1_stall, s1_freeze, s1_ack;
   logic [6:0]  s1_flush;
   logic [2:0]  s1_sa, s1_sb;
   logic [31:0] s1_ret, s1_stc, s1_flc;

   pipe_hazard_ctrl #(.NUM_STAGES(5), .LOAD_READY_STAGE(3), .BRANCH_STAGE(3),
                      .REG_IDX_W(5), .CNT_W(32)) u_dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem), .mem_busy(mem_busy), .redirect(redirect),
      .stall(s0_stall), .freeze(s0_freeze), .flush_mask(s0_flush), .redirect_ack(s0_ack),
      .fwd_sel_a(s0_sa), .fwd_sel_b(s0_sb),
      .retired_cnt(s0_ret), .stall_cnt(s0_stc), .flush_cnt(s0_flc));

   pipe_hazard_ctrl #(.NUM_STAGES(7), .LOAD_READY_STAGE(4), .BRANCH_STAGE(4),
                      .REG_IDX_W(5), .CNT_W(32)) u_dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem), .mem_busy(mem_busy), .redirect(redirect),
      .stall(s1_stall), .freeze(s1_freeze), .flush_mask(s1_flush), .redirect_ack(s1_ack),
      .fwd_sel_a(s1_sa), .fwd_sel_b(s1_sb),
      .retired_cnt(s1_ret), .stall_cnt(s1_stc), .flush_cnt(s1_flc));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: a set of in-flight instructions, each tagged with its stage.
   int          m_n [2];
   int          m_l [2];
   int          m_b [2];
   bit          m_v  [2][8];
   int          m_st [2][8];
   bit          m_wr [2][8];
   bit          m_ld [2][8];
   logic [4:0]  m_rd [2][8];
   int unsigned m_ret [2];
   int unsigned m_stc [2];
   int unsigned m_flc [2];

   logic       e_stall [2];
   logic       e_ack   [2];
   logic [7:0] e_flush [2];
   logic [2:0] e_sa    [2];
   logic [2:0] e_sb    [2];

   task automatic youngest(input int d, input logic used, input logic [4:0] idx,
                           output int sel, output bit lu);
      int best;
      best = 99;
      sel  = 0;
      lu   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (used && idx != 5'd0 && m_v[d][i] && m_wr[d][i] && m_rd[d][i] == idx && m_st[d][i] < best) begin
            best = m_st[d][i];
            sel  = m_st[d][i];
            lu   = m_ld[d][i] && (m_st[d][i] < m_l[d]);
         end
      end
   endtask

   task automatic model_eval(input int d);
      int sa, sb;
      bit la, lb, haz;
      youngest(d, id_rs1_used, id_rs1, sa, la);
      youngest(d, id_rs2_used, id_rs2, sb, lb);
      haz        = id_valid && (la || lb);
      e_ack[d]   = !rst && !mem_busy && redirect;
      e_flush[d] = e_ack[d] ? ((8'd1 << m_b[d]) - 8'd1) : 8'd0;
      e_stall[d] = !rst && !mem_busy && !redirect && haz;
      e_sa[d]    = 3'(sa);
      e_sb[d]    = 3'(sb);
   endtask

   task automatic model_step(input int d);
      bit placed;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_v[d][i] = 1'b0;
         m_ret[d] = 0;
         m_stc[d] = 0;
         m_flc[d] = 0;
         return;
      end
      if (mem_busy) return;
      for (int i = 0; i < 8; i++)
         if (m_v[d][i] && m_st[d][i] == m_n[d] - 1) m_ret[d]++;
      if (e_ack[d]) begin
         for (int i = 0; i < 8; i++)
            if (m_v[d][i] && m_st[d][i] < m_b[d]) m_v[d][i] = 1'b0;
         m_flc[d]++;
      end
      for (int i = 0; i < 8; i++) begin
         if (m_v[d][i]) begin
            m_st[d][i]++;
            if (m_st[d][i] > m_n[d] - 1) m_v[d][i] = 1'b0;
         end
      end
      if (e_stall[d]) m_stc[d]++;
      else if (!e_ack[d] && id_valid) begin
         placed = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (!placed && !m_v[d][i]) begin
               placed     = 1'b1;
               m_v[d][i]  = 1'b1;
               m_st[d][i] = 2;
               m_wr[d][i] = id_reg_wr;
               m_ld[d][i] = id_rd_mem;
               m_rd[d][i] = id_rd;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("d0_stall",  64'(s0_stall),  64'(e_stall[0]));
      chk("d0_freeze", 64'(s0_freeze), 64'(mem_busy));
      chk("d0_flush",  64'(s0_flush),  64'(e_flush[0]));
      chk("d0_ack",    64'(s0_ack),    64'(e_ack[0]));
      chk("d0_sel_a",  64'(s0_sa),     64'(e_sa[0]));
      chk("d0_sel_b",  64'(s0_sb),     64'(e_sb[0]));
      chk("d0_retired",64'(s0_ret),    64'(m_ret[0]));
      chk("d0_stalls", 64'(s0_stc),    64'(m_stc[0]));
      chk("d0_flushes",64'(s0_flc),    64'(m_flc[0]));
      chk("d1_stall",  64'(s1_stall),  64'(e_stall[1]));
      chk("d1_freeze", 64'(s1_freeze), 64'(mem_busy));
      chk("d1_flush",  64'(s1_flush),  64'(e_flush[1]));
      chk("d1_ack",    64'(s1_ack),    64'(e_ack[1]));
      chk("d1_sel_a",  64'(s1_sa),     64'(e_sa[1]));
      chk("d1_sel_b",  64'(s1_sb),     64'(e_sb[1]));
      chk("d1_retired",64'(s1_ret),    64'(m_ret[1]));
      chk("d1_stalls", 64'(s1_stc),    64'(m_stc[1]));
      chk("d1_flushes",64'(s1_flc),    64'(m_flc[1]));
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval(0);
      model_eval(1);
      if (!rst) compare_all();
   endtask

   task automatic advance();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rd, input logic wr, input logic ld);
      id_valid = v;   id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
      id_rd    = rd;  id_reg_wr = wr; id_rd_mem = ld;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      settle();
      advance();
      rst = 1'b0;
   endtask

   bit red_pend;

   initial begin
      m_n[0] = 5; m_l[0] = 3; m_b[0] = 3;
      m_n[1] = 7; m_l[1] = 4; m_b[1] = 4;
      mem_busy = 1'b0;
      redirect = 1'b0;
      set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      do_reset();

      // reset state
      settle();
      chk("rst_d0_stall", 64'(s0_stall), 64'd0);
      chk("rst_d0_ret",   64'(s0_ret),   64'd0);
      chk("rst_d1_flush", 64'(s1_flush), 64'd0);
      chk("rst_d1_sel_a", 64'(s1_sa),    64'd0);
      advance();

      // ten back-to-back independent instructions
      do_reset();
      for (int c = 0; c <= 15; c++) begin
         if (c < 10) set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(c + 1), 1'b1, 1'b0);
         else        set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
         settle();
         if (c == 12) chk("ret9_d0",  64'(s0_ret), 64'd9);
         if (c == 13) chk("ret10_d0", 64'(s0_ret), 64'd10);
         if (c == 14) chk("ret9_d1",  64'(s1_ret), 64'd9);
         if (c == 15) chk("ret10_d1", 64'(s1_ret), 64'd10);
         advance();
      end

      // load-use stall
      do_reset();
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      settle(); advance();
      set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      settle();
      chk("lu_stall_d0", 64'(s0_stall), 64'd1);
      chk("lu_stall_d1", 64'(s1_stall), 64'd1);
      advance();
      settle();
      chk("lu_fwd_d0",    64'(s0_sa),    64'd3);
      chk("lu_go_d0",     64'(s0_stall), 64'd0);
      chk("lu_cnt_d0",    64'(s0_stc),   64'd1);
      chk("lu_stall2_d1", 64'(s1_stall), 64'd1);
      advance();
      settle();
      chk("lu_fwd_d1", 64'(s1_sa),    64'd4);
      chk("lu_go_d1",  64'(s1_stall), 64'd0);
      chk("lu_cnt_d1", 64'(s1_stc),   64'd2);
      advance();

      // forwarding priority and x0
      do_reset();
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); settle(); advance();
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); settle(); advance();
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); settle(); advance();
      set_dec(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
      settle();
      chk("fwd_young_d0", 64'(s0_sb), 64'd2);
      chk("fwd_young_d1", 64'(s1_sb), 64'd2);
      advance();
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); settle(); advance();
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
      settle();
      chk("x0_sel_d0",   64'(s0_sb),    64'd0);
      chk("x0_stall_d0", 64'(s0_stall), 64'd0);
      chk("x0_stall_d1", 64'(s1_stall), 64'd0);
      advance();

      // redirect flush
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
      redirect = 1'b1;
      settle();
      chk("rd_ack_d0",   64'(s0_ack),   64'd1);
      chk("rd_mask_d0",  64'(s0_flush), 64'h07);
      chk("rd_mask_d1",  64'(s1_flush), 64'h0f);
      chk("rd_stall_d0", 64'(s0_stall), 64'd0);
      advance();
      redirect = 1'b0;
      set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      settle();
      chk("rd_cnt_d0", 64'(s0_flc), 64'd1);
      advance();

      // freeze with pending redirect
      mem_busy = 1'b1;
      redirect = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("frz_ack_d0", 64'(s0_ack),    64'd0);
         chk("frz_ack_d1", 64'(s1_ack),    64'd0);
         chk("frz_out_d1", 64'(s1_freeze), 64'd1);
         advance();
      end
      mem_busy = 1'b0;
      settle();
      chk("frz_late_ack_d0", 64'(s0_ack), 64'd1);
      chk("frz_late_ack_d1", 64'(s1_ack), 64'd1);
      advance();
      redirect = 1'b0;

      // reset in the middle of a stall
      do_reset();
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1); settle(); advance();
      set_dec(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
      settle();
      chk("pre_rst_stall_d0", 64'(s0_stall), 64'd1);
      advance();
      do_reset();
      settle();
      chk("post_rst_stall_d0", 64'(s0_stall), 64'd0);
      chk("post_rst_stc_d0",   64'(s0_stc),   64'd0);
      chk("post_rst_stc_d1",   64'(s1_stc),   64'd0);
      advance();

      // randomized traffic
      red_pend = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (rst) red_pend = 1'b0;
         else if (!red_pend && $urandom_range(0, 7) == 0) red_pend = 1'b1;
         redirect = red_pend;
         mem_busy = ($urandom_range(0, 5) == 0);
         set_dec(1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0));
         settle();
         if (e_ack[0]) red_pend = 1'b0;
         advance();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
